// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the block-structured ISA front end.
// Holds the opcode-class encodings, the fixed field widths, and the packed
// bundle of decoded fields passed from decoder_comb to the decoder register stage.
package isa_pkg;

    localparam logic [2:0] OP_ALU2  = 3'b000;
    localparam logic [2:0] OP_ALUI  = 3'b001;
    localparam logic [2:0] OP_BR    = 3'b010;
    localparam logic [2:0] OP_TGT34 = 3'b011;
    localparam logic [2:0] OP_IMMHI = 3'b100;
    localparam logic [2:0] OP_HDR   = 3'b101;

    localparam int INSTR_W  = 32;
    localparam int OP_W     = 3;
    localparam int PREFIX_W = 3;
    localparam int NALLOC_W = 7;
    localparam int FUNCT_W  = 4;
    localparam int IMMLO_W  = 6;
    localparam int IMMHI_W  = 26;
    localparam int OFFSET_W = 10;
    localparam int TA_W     = 6;
    localparam int TT_W     = 2;

    typedef struct packed {
        logic                illegal;
        logic [OP_W-1:0]     op;
        logic [PREFIX_W-1:0] prefix;
        logic [NALLOC_W-1:0] nalloc;
        logic                end_f;
        logic [FUNCT_W-1:0]  funct;
        logic                immab;
        logic [IMMLO_W-1:0]  immlo;
        logic [IMMHI_W-1:0]  immhi;
        logic [OFFSET_W-1:0] offset;
        logic [TA_W-1:0]     ta1;
        logic [TA_W-1:0]     ta2;
        logic [TA_W-1:0]     ta3;
        logic [TA_W-1:0]     ta4;
        logic [TT_W-1:0]     tt1;
        logic [TT_W-1:0]     tt2;
        logic [TT_W-1:0]     tt3;
        logic [TT_W-1:0]     tt4;
    } dec_fields_t;

endpackage

// File: rtl/decoder_comb.sv
// decoder_comb: combinational field slicer for one instruction word.
// Ports:
//   instruction  in  32-bit instruction word
//   fields       out decoded field bundle; fields not used by the opcode
//                    class are 0, reserved bits are ignored
module decoder_comb
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0] instruction,
    output dec_fields_t        fields
);

    logic [OP_W-1:0] op;
    assign op = instruction[31:29];

    always_comb begin
        fields    = '0;
        fields.op = op;
        case (op)
            OP_ALU2, OP_ALUI: begin
                fields.funct = instruction[28:25];
                fields.immab = instruction[24];
                fields.immlo = instruction[23:18];
                fields.tt1   = instruction[15:14];
                fields.ta1   = instruction[13:8];
                fields.tt2   = instruction[7:6];
                fields.ta2   = instruction[5:0];
            end
            OP_BR: begin
                fields.funct  = instruction[28:25];
                fields.immab  = instruction[24];
                fields.immlo  = instruction[23:18];
                fields.offset = instruction[9:0];
            end
            OP_TGT34: begin
                fields.tt3 = instruction[15:14];
                fields.ta3 = instruction[13:8];
                fields.tt4 = instruction[7:6];
                fields.ta4 = instruction[5:0];
            end
            OP_IMMHI: begin
                fields.prefix = instruction[28:26];
                fields.immhi  = instruction[25:0];
            end
            OP_HDR: begin
                fields.end_f  = instruction[28];
                fields.nalloc = instruction[6:0];
            end
            default: begin
                // 110/111 are reserved classes: only op and illegal survive
                fields.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decoder.sv
// decoder: single-cycle registered instruction-field decoder.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   instr_valid       instruction word present this cycle
//   instruction       32-bit instruction word
//   out_valid         decoded fields valid (one cycle after instr_valid)
//   illegal           reserved opcode class 110/111
//   op, prefix, nalloc, endF, funct, immab, immlo, immhi, offset,
//   ta1..ta4, tt1..tt4  registered decoded fields
// Fields hold their last value while instr_valid is low.
module decoder
    import isa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                out_valid,
    output logic                illegal,
    output logic [OP_W-1:0]     op,
    output logic [PREFIX_W-1:0] prefix,
    output logic [NALLOC_W-1:0] nalloc,
    output logic                endF,
    output logic [FUNCT_W-1:0]  funct,
    output logic                immab,
    output logic [IMMLO_W-1:0]  immlo,
    output logic [IMMHI_W-1:0]  immhi,
    output logic [OFFSET_W-1:0] offset,
    output logic [TA_W-1:0]     ta1,
    output logic [TA_W-1:0]     ta2,
    output logic [TA_W-1:0]     ta3,
    output logic [TA_W-1:0]     ta4,
    output logic [TT_W-1:0]     tt1,
    output logic [TT_W-1:0]     tt2,
    output logic [TT_W-1:0]     tt3,
    output logic [TT_W-1:0]     tt4
);

    dec_fields_t next_fields;
    dec_fields_t fields_q;
    logic        valid_q;

    decoder_comb u_comb (
        .instruction (instruction),
        .fields      (next_fields)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fields_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= instr_valid;
            if (instr_valid)
                fields_q <= next_fields;
        end
    end

    assign out_valid = valid_q;
    assign illegal   = fields_q.illegal;
    assign op        = fields_q.op;
    assign prefix    = fields_q.prefix;
    assign nalloc    = fields_q.nalloc;
    assign endF      = fields_q.end_f;
    assign funct     = fields_q.funct;
    assign immab     = fields_q.immab;
    assign immlo     = fields_q.immlo;
    assign immhi     = fields_q.immhi;
    assign offset    = fields_q.offset;
    assign ta1       = fields_q.ta1;
    assign ta2       = fields_q.ta2;
    assign ta3       = fields_q.ta3;
    assign ta4       = fields_q.ta4;
    assign tt1       = fields_q.tt1;
    assign tt2       = fields_q.tt2;
    assign tt3       = fields_q.tt3;
    assign tt4       = fields_q.tt4;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: scoreboard bench for decoder. Stimulus pushes hand-computed
// expected field bundles; a monitor pops and compares whenever out_valid is high.
module tb_decoder;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        out_valid, illegal, immab, endF;
    logic [2:0]  op, prefix;
    logic [6:0]  nalloc;
    logic [3:0]  funct;
    logic [5:0]  immlo, ta1, ta2, ta3, ta4;
    logic [25:0] immhi;
    logic [9:0]  offset;
    logic [1:0]  tt1, tt2, tt3, tt4;

    int total = 0;
    int bad   = 0;
    dec_fields_t exp_q[$];
    dec_fields_t act;

    always #5 clk = ~clk;

    decoder dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .out_valid(out_valid), .illegal(illegal), .op(op), .prefix(prefix),
        .nalloc(nalloc), .endF(endF), .funct(funct), .immab(immab),
        .immlo(immlo), .immhi(immhi), .offset(offset),
        .ta1(ta1), .ta2(ta2), .ta3(ta3), .ta4(ta4),
        .tt1(tt1), .tt2(tt2), .tt3(tt3), .tt4(tt4)
    );

    always_comb begin
        act         = '0;
        act.illegal = illegal;
        act.op      = op;
        act.prefix  = prefix;
        act.nalloc  = nalloc;
        act.end_f   = endF;
        act.funct   = funct;
        act.immab   = immab;
        act.immlo   = immlo;
        act.immhi   = immhi;
        act.offset  = offset;
        act.ta1 = ta1; act.ta2 = ta2; act.ta3 = ta3; act.ta4 = ta4;
        act.tt1 = tt1; act.tt2 = tt2; act.tt3 = tt3; act.tt4 = tt4;
    end

    task automatic check_fields(input string name, input dec_fields_t a, input dec_fields_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic check_bit(input string name, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, a, e);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 want no pending word");
            end else begin
                check_fields("scoreboard", act, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] w, input dec_fields_t e);
        instr_valid = 1'b1;
        instruction = w;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle;
        instr_valid = 1'b0;
        instruction = $urandom;
        @(posedge clk); #1;
    endtask

    dec_fields_t e, last;

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b1;
        instruction = 32'h1234_5678;
        @(posedge clk); #1;
        instruction = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_fields("reset_fields", act, '0);
        rst = 1'b0;

        // ALU2
        e = '0; e.op = 3'd0; e.funct = 4'd1; e.immab = 1'b0; e.immlo = 6'h15;
        e.tt1 = 2'd2; e.ta1 = 6'h2A; e.tt2 = 2'd3; e.ta2 = 6'h3C;
        send(32'b000_0001_0_010101_00_10_101010_11_111100, e);

        // ALUI with reserved [17:16] set
        e = '0; e.op = 3'd1; e.funct = 4'hF; e.immab = 1'b1; e.immlo = 6'h3F;
        e.tt1 = 2'd1; e.ta1 = 6'h01; e.tt2 = 2'd0; e.ta2 = 6'h02;
        send(32'b001_1111_1_111111_11_01_000001_00_000010, e);

        // BR then TGT34 back-to-back
        e = '0; e.op = 3'd2; e.funct = 4'd3; e.immlo = 6'h15; e.offset = 10'h2CE;
        send(32'b010_0011_0_010101_00000000_1011001110, e);
        e = '0; e.op = 3'd3; e.tt3 = 2'd2; e.ta3 = 6'h2A; e.tt4 = 2'd3; e.ta4 = 6'h3C;
        send(32'b011_0000000000000_10_101010_11_111100, e);

        // IMMHI, IMMHI with prefix, HDR, HDR with endF and reserved bits
        e = '0; e.op = 3'd4; e.prefix = 3'd0; e.immhi = 26'h2AA_AAAA;
        send(32'b100_000_10101010101010101010101010, e);
        e = '0; e.op = 3'd4; e.prefix = 3'd5; e.immhi = 26'h3FF_FFFF;
        send(32'b100_101_11111111111111111111111111, e);
        e = '0; e.op = 3'd5; e.end_f = 1'b0; e.nalloc = 7'h73;
        send(32'b101_0_000000000000000000000_1110011, e);
        e = '0; e.op = 3'd5; e.end_f = 1'b1; e.nalloc = 7'h73;
        send(32'b101_1_101010101010101010101_1110011, e);

        // Reserved classes
        e = '0; e.op = 3'd6; e.illegal = 1'b1;
        send(32'hDFFF_FFFF, e);
        e = '0; e.op = 3'd7; e.illegal = 1'b1;
        send(32'hE000_FFFF, e);
        last = e;

        // Hold: out_valid drops, fields keep the last decode
        for (int i = 0; i < 3; i++) begin
            idle();
            check_bit("hold_out_valid", out_valid, 1'b0);
            check_fields("hold_fields", act, last);
        end

        // Reset wins over a valid word in the same cycle
        rst = 1'b1;
        instr_valid = 1'b1;
        instruction = 32'b000_0001_0_010101_00_10_101010_11_111100;
        @(posedge clk); #1;
        check_bit("midreset_out_valid", out_valid, 1'b0);
        check_fields("midreset_fields", act, '0);
        rst = 1'b0;

        // Decoding resumes right after reset drops
        e = '0; e.op = 3'd2; e.funct = 4'hA; e.immab = 1'b1; e.immlo = 6'h01; e.offset = 10'h3FF;
        send(32'b010_1010_1_000001_11111111_1111111111, e);
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_words: got %0d outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
